// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipe_ctrl: hazard/branch/divide
// status in, per-stage hold/flush requests and debug status out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_jump_en;
  logic             ex_prd_taken;
  logic             ex_div_start;
  logic             div_done;
  logic             id_load_use;

  logic [4:0]       hold_en;
  logic [4:0]       flush;
  logic             prd_fail;
  logic             div_timeout;
  logic [CNT_W-1:0] mispredict_cnt;
  logic [1:0]       state;

  // Datapath side: reports hazards, consumes control requests.
  modport master (
    output ex_valid, ex_branch, ex_jump_en, ex_prd_taken,
           ex_div_start, div_done, id_load_use,
    input  hold_en, flush, prd_fail, div_timeout, mispredict_cnt, state
  );

  // Control side.
  modport slave (
    input  ex_valid, ex_branch, ex_jump_en, ex_prd_taken,
           ex_div_start, div_done, id_load_use,
    output hold_en, flush, prd_fail, div_timeout, mispredict_cnt, state
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: mispredict redirect/kill, divide stall with
// watchdog, and load-use refetch. Stage bits: 0=PC, 1=IF/ID, 2=ID/EX, 3=EX/MEM, 4=MEM/WB.
module pipe_ctrl #(
  parameter int FLUSH_CYC   = 2,
  parameter int DIV_TIMEOUT = 34,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rstn,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    DIV_WAIT = 2'd2,
    RSVD     = 2'd3
  } state_t;

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC + 1) : 1;
  localparam int DW = $clog2(DIV_TIMEOUT);

  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV_TIMEOUT - 1);

  localparam logic [4:0] HOLD_PC   = 5'b00001;
  localparam logic [4:0] HOLD_DIV  = 5'b01110;
  localparam logic [4:0] FLUSH_FE  = 5'b00110;
  localparam logic [4:0] FLUSH_DIV = 5'b10000;

  state_t           state, state_nxt;
  logic [FW-1:0]    flush_cnt, flush_nxt;
  logic [DW-1:0]    wait_cnt, wait_nxt;
  logic [CNT_W-1:0] mis_cnt;
  logic             cnt_inc;

  logic [4:0]       hold_c, flush_c;
  logic             prd_fail_c, timeout_c;
  logic             mis;

  assign mis = bus.ex_valid & bus.ex_branch & (bus.ex_jump_en != bus.ex_prd_taken);

  // NOTE: state and counters use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation behaviour.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= RUN;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_nxt;
      wait_cnt  <= wait_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mis_cnt <= '0;
    end else if (cnt_inc && (mis_cnt != '1)) begin
      mis_cnt <= mis_cnt + CNT_W'(1);
    end
  end

  // NOTE: every variable written below gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    flush_nxt  = flush_cnt;
    wait_nxt   = wait_cnt;
    cnt_inc    = 1'b0;
    hold_c     = '0;
    flush_c    = '0;
    prd_fail_c = 1'b0;
    timeout_c  = 1'b0;

    unique case (state)
      RUN: begin
        if (mis) begin
          // Mispredict wins over a simultaneous divide issue; the divide is dropped.
          prd_fail_c = 1'b1;
          hold_c     = HOLD_PC;
          flush_c    = FLUSH_FE;
          cnt_inc    = 1'b1;
          flush_nxt  = FLUSH_LOAD;
          state_nxt  = FLUSH;
        end else if (bus.ex_div_start) begin
          hold_c    = HOLD_DIV;
          flush_c   = FLUSH_DIV;
          wait_nxt  = '0;
          state_nxt = DIV_WAIT;
        end else if (bus.id_load_use) begin
          hold_c  = HOLD_PC;
          flush_c = FLUSH_FE;
        end
      end

      FLUSH: begin
        // Wrong-path instructions are in EX/ID here, so their status is ignored.
        flush_c = FLUSH_FE;
        if (flush_cnt <= FW'(1)) begin
          flush_nxt = '0;
          state_nxt = RUN;
        end else begin
          flush_nxt = flush_cnt - FW'(1);
        end
      end

      DIV_WAIT: begin
        if (bus.div_done) begin
          state_nxt = RUN;
        end else if (wait_cnt == DIV_LAST) begin
          timeout_c = 1'b1;
          state_nxt = RUN;
        end else begin
          hold_c   = HOLD_DIV;
          flush_c  = FLUSH_DIV;
          wait_nxt = wait_cnt + DW'(1);
        end
      end

      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Combinational outputs are gated by reset so an asserted rstn silences them at once,
  // independent of whatever the datapath is presenting.
  assign bus.hold_en        = rstn ? hold_c : '0;
  assign bus.flush          = rstn ? flush_c : '0;
  assign bus.prd_fail       = rstn & prd_fail_c;
  assign bus.div_timeout    = rstn & timeout_c;
  assign bus.mispredict_cnt = mis_cnt;
  assign bus.state          = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a cycle-level behavioural model queues the expected
// outputs for each driven cycle; a negedge monitor pops and compares.
module tb_pipe_ctrl;

  localparam int FLUSH_CYC   = 2;
  localparam int DIV_TIMEOUT = 34;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic valid;
    logic branch;
    logic jump;
    logic prd;
    logic div_start;
    logic done;
    logic lu;
  } in_t;

  typedef struct packed {
    logic [4:0]       hold;
    logic [4:0]       flush;
    logic             prd_fail;
    logic             timeout;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       state;
  } obs_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .FLUSH_CYC  (FLUSH_CYC),
    .DIV_TIMEOUT(DIV_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_tag  = 0;

  // Reference model state: what the pipeline is doing, in plain terms.
  int flush_left = 0;   // wrong-path kill cycles still to go
  bit dividing   = 0;   // a divide is outstanding
  int div_cycles = 0;   // DIV_WAIT cycles spent so far
  int mis_total  = 0;   // saturating mispredict tally

  localparam in_t IDLE = '0;

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hold=%b flush=%b prd_fail=%b timeout=%b cnt=%0d state=%0d, expected hold=%b flush=%b prd_fail=%b timeout=%b cnt=%0d state=%0d",
               name, act.hold, act.flush, act.prd_fail, act.timeout, act.cnt, act.state,
               exp.hold, exp.flush, exp.prd_fail, exp.timeout, exp.cnt, exp.state);
    end
  endtask

  task automatic model(input logic r, input in_t i, output obs_t o);
    bit mis;
    o = '0;
    if (!r) begin
      flush_left = 0;
      dividing   = 0;
      div_cycles = 0;
      mis_total  = 0;
      return;
    end
    o.cnt   = CNT_W'(mis_total);
    o.state = (flush_left > 0) ? 2'd1 : (dividing ? 2'd2 : 2'd0);
    if (flush_left > 0) begin
      o.flush = 5'b00110;
      flush_left--;
    end else if (dividing) begin
      div_cycles++;
      if (i.done) begin
        dividing = 0;
      end else if (div_cycles == DIV_TIMEOUT) begin
        o.timeout = 1'b1;
        dividing  = 0;
      end else begin
        o.hold  = 5'b01110;
        o.flush = 5'b10000;
      end
    end else begin
      mis = i.valid && i.branch && (i.jump != i.prd);
      if (mis) begin
        o.prd_fail = 1'b1;
        o.hold     = 5'b00001;
        o.flush    = 5'b00110;
        if (mis_total < CNT_MAX) mis_total++;
        flush_left = FLUSH_CYC;
      end else if (i.div_start) begin
        o.hold     = 5'b01110;
        o.flush    = 5'b10000;
        dividing   = 1;
        div_cycles = 0;
      end else if (i.lu) begin
        o.hold  = 5'b00001;
        o.flush = 5'b00110;
      end
    end
  endtask

  task automatic apply(input in_t i);
    bus.ex_valid     = i.valid;
    bus.ex_branch    = i.branch;
    bus.ex_jump_en   = i.jump;
    bus.ex_prd_taken = i.prd;
    bus.ex_div_start = i.div_start;
    bus.div_done     = i.done;
    bus.id_load_use  = i.lu;
  endtask

  // One cycle of stimulus: inputs (and rstn) change 1 time unit after the edge.
  task automatic step(input logic r, input in_t i);
    obs_t e;
    @(posedge clk);
    #1;
    rstn = r;
    apply(i);
    model(r, i, e);
    exp_q.push_back(e);
  endtask

  function automatic in_t mk_branch(input logic jump, input logic prd);
    in_t t = '0;
    t.valid  = 1'b1;
    t.branch = 1'b1;
    t.jump   = jump;
    t.prd    = prd;
    return t;
  endfunction

  function automatic in_t mk_div();
    in_t t = '0;
    t.valid     = 1'b1;
    t.div_start = 1'b1;
    return t;
  endfunction

  function automatic in_t mk_done();
    in_t t = '0;
    t.done = 1'b1;
    return t;
  endfunction

  function automatic in_t mk_lu();
    in_t t = '0;
    t.lu = 1'b1;
    return t;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = {bus.hold_en, bus.flush, bus.prd_fail, bus.div_timeout, bus.mispredict_cnt, bus.state};
      check($sformatf("cycle%0d", cyc_tag), a, e);
      cyc_tag++;
    end
  end

  initial begin
    in_t r;
    // Reset held with every input active: all outputs stay low.
    apply('1);
    for (int k = 0; k < 3; k++) step(1'b0, '1);
    step(1'b1, IDLE);

    // Mispredict (predicted not-taken, resolved taken), then 2 kill cycles.
    step(1'b1, mk_branch(1'b1, 1'b0));
    for (int k = 0; k < 3; k++) step(1'b1, IDLE);

    // Correct prediction: nothing happens.
    step(1'b1, mk_branch(1'b1, 1'b1));
    step(1'b1, mk_lu());
    step(1'b1, IDLE);

    // Divide completing on the 10th wait cycle.
    step(1'b1, mk_div());
    for (int k = 0; k < 9; k++) step(1'b1, IDLE);
    step(1'b1, mk_done());
    step(1'b1, IDLE);

    // Divide that never completes: watchdog on the 34th wait cycle.
    step(1'b1, mk_div());
    for (int k = 0; k < DIV_TIMEOUT + 2; k++) step(1'b1, IDLE);

    // Done arriving on the would-be timeout cycle: done wins.
    step(1'b1, mk_div());
    for (int k = 0; k < DIV_TIMEOUT - 1; k++) step(1'b1, IDLE);
    step(1'b1, mk_done());
    step(1'b1, IDLE);

    // Mispredict together with divide start: divide is dropped.
    r = mk_branch(1'b0, 1'b1);
    r.div_start = 1'b1;
    step(1'b1, r);
    for (int k = 0; k < 3; k++) step(1'b1, IDLE);

    // Counter saturation with load-use requests arriving during FLUSH.
    for (int m = 0; m < 5; m++) begin
      step(1'b1, mk_branch(m[0], ~m[0]));
      step(1'b1, mk_lu());
      step(1'b1, mk_lu());
    end
    step(1'b1, IDLE);

    // Reset asserted mid-FLUSH and mid-DIV_WAIT, then released.
    step(1'b1, mk_branch(1'b0, 1'b1));
    step(1'b0, '1);
    step(1'b1, IDLE);
    step(1'b1, mk_div());
    for (int k = 0; k < 4; k++) step(1'b1, IDLE);
    step(1'b0, mk_done());
    step(1'b1, IDLE);
    step(1'b1, IDLE);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      in_t t;
      logic rr;
      t.valid     = ($urandom_range(3) != 0);
      t.branch    = $urandom_range(1);
      t.jump      = $urandom_range(1);
      t.prd       = $urandom_range(1);
      t.div_start = ($urandom_range(7) == 0);
      t.done      = ($urandom_range(19) == 0);
      t.lu        = ($urandom_range(3) == 0);
      rr          = ($urandom_range(499) != 0);
      step(rr, t);
    end
    step(1'b1, IDLE);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
